// File: rtl/cr16_datapath_seq_fsm.sv
// cr16_datapath_seq_fsm: start/done sequencer driving the CR16 register file + ALU through fib/inc test programs
//   I_CLK, I_NRESET (async, active-low), I_ENABLE (low = stall), I_START, I_MODE (00 fib, 01 inc, 1x fib then inc)
//   O_OPCODE, O_READ_PORT_A_SEL/B_SEL, O_IMM_SEL, O_REG_ENABLE (one-hot write), O_PRELOAD_IMM, O_BUSY, O_DONE
module cr16_datapath_seq_fsm #(
  parameter int REG_COUNT = 8,
  parameter int DATA_WIDTH = 16,
  parameter int INC_IMM = 1,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_MOVI = 4'b1101
) (
  input  logic                  I_CLK,
  input  logic                  I_NRESET,
  input  logic                  I_ENABLE,
  input  logic                  I_START,
  input  logic [1:0]            I_MODE,
  output logic [3:0]            O_OPCODE,
  output logic [3:0]            O_READ_PORT_A_SEL,
  output logic [3:0]            O_READ_PORT_B_SEL,
  output logic                  O_IMM_SEL,
  output logic [15:0]           O_REG_ENABLE,
  output logic [DATA_WIDTH-1:0] O_PRELOAD_IMM,
  output logic                  O_BUSY,
  output logic                  O_DONE
);
  typedef enum logic [2:0] {IDLE, LOAD0, LOAD1, FIB, INC, DONE} state_t;
  localparam logic [3:0] LAST = 4'(REG_COUNT - 1);
  localparam logic [DATA_WIDTH-1:0] IMM_ONE = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] IMM_INC = DATA_WIDTH'(INC_IMM);
  state_t state, state_n;
  logic [3:0] k, k_n;
  logic [1:0] mode, mode_n;
  logic [15:0] reg_en_q;
  logic load_n, busy_n;
  always_comb begin
    state_n = state;
    k_n = k;
    mode_n = mode;
    if (I_ENABLE)
      case (state)
        IDLE: if (I_START) begin
          mode_n = I_MODE;
          state_n = (I_MODE == 2'b01) ? INC : LOAD0;
          k_n = 4'd0;
        end
        LOAD0: begin
          state_n = LOAD1;
          k_n = 4'd1;
        end
        LOAD1: begin
          state_n = (REG_COUNT > 2) ? FIB : mode[1] ? INC : DONE;
          k_n = (REG_COUNT > 2) ? 4'd2 : 4'd0;
        end
        FIB: begin
          state_n = (k != LAST) ? FIB : mode[1] ? INC : DONE;
          k_n = (k != LAST) ? k + 4'd1 : 4'd0;
        end
        INC: begin
          state_n = (k != LAST) ? INC : DONE;
          k_n = (k != LAST) ? k + 4'd1 : 4'd0;
        end
        default: begin
          state_n = IDLE;
          k_n = 4'd0;
        end
      endcase
    load_n = (state_n == LOAD0) || (state_n == LOAD1);
    busy_n = load_n || (state_n == FIB) || (state_n == INC);
  end
  // Outputs are registered from the next-state decode, so they line up with the state they describe.
  always_ff @(posedge I_CLK or negedge I_NRESET)
    if (!I_NRESET) begin
      state <= IDLE;
      k <= 4'd0;
      mode <= 2'b00;
      O_OPCODE <= 4'd0;
      O_READ_PORT_A_SEL <= 4'd0;
      O_READ_PORT_B_SEL <= 4'd0;
      O_IMM_SEL <= 1'b0;
      reg_en_q <= 16'd0;
      O_PRELOAD_IMM <= '0;
      O_BUSY <= 1'b0;
      O_DONE <= 1'b0;
    end else begin
      state <= state_n;
      k <= k_n;
      mode <= mode_n;
      O_OPCODE <= load_n ? OP_MOVI : busy_n ? OP_ADD : 4'd0;
      O_READ_PORT_A_SEL <= (state_n == FIB) ? k_n - 4'd2 : (state_n == INC) ? k_n : 4'd0;
      O_READ_PORT_B_SEL <= (state_n == FIB) ? k_n - 4'd1 : 4'd0;
      O_IMM_SEL <= load_n || (state_n == INC);
      reg_en_q <= busy_n ? 16'd1 << k_n : 16'd0;
      O_PRELOAD_IMM <= load_n ? IMM_ONE : (state_n == INC) ? IMM_INC : '0;
      O_BUSY <= busy_n;
      O_DONE <= state_n == DONE;
    end
  // A stalled step must not commit, so the write enable is gated combinationally.
  assign O_REG_ENABLE = reg_en_q & {16{I_ENABLE}};
endmodule

// File: tb/tb_cr16_datapath_seq_fsm.sv
// tb_cr16_datapath_seq_fsm: checks 8- and 16-register sequencers against a step-list model plus a register-file model
module tb_cr16_datapath_seq_fsm;
  typedef struct packed {
    logic [3:0] op, a, b;
    logic isel;
    logic [15:0] en, imm;
    logic busy, done;
  } step_t;
  logic I_CLK = 0, I_NRESET = 0, I_ENABLE = 1, I_START = 0;
  logic [1:0] I_MODE = 2'b00;
  logic [3:0] op[2], asel[2], bsel[2];
  logic isel[2], busy[2], done[2];
  logic [15:0] ren[2], imm[2];
  step_t prog[2][0:40];
  int len[2], pos[2];
  logic [15:0] rf[2][16];
  int checks = 0, passes = 0, lat;
  bit seen_top = 0;
  logic [3:0] a3;
  logic s3;
  int f8[8], i8[8];
  always #5 I_CLK = ~I_CLK;
  cr16_datapath_seq_fsm #(.REG_COUNT(8)) dut8 (
    .I_CLK(I_CLK), .I_NRESET(I_NRESET), .I_ENABLE(I_ENABLE), .I_START(I_START), .I_MODE(I_MODE),
    .O_OPCODE(op[0]), .O_READ_PORT_A_SEL(asel[0]), .O_READ_PORT_B_SEL(bsel[0]), .O_IMM_SEL(isel[0]),
    .O_REG_ENABLE(ren[0]), .O_PRELOAD_IMM(imm[0]), .O_BUSY(busy[0]), .O_DONE(done[0]));
  cr16_datapath_seq_fsm #(.REG_COUNT(16)) dut16 (
    .I_CLK(I_CLK), .I_NRESET(I_NRESET), .I_ENABLE(I_ENABLE), .I_START(I_START), .I_MODE(I_MODE),
    .O_OPCODE(op[1]), .O_READ_PORT_A_SEL(asel[1]), .O_READ_PORT_B_SEL(bsel[1]), .O_IMM_SEL(isel[1]),
    .O_REG_ENABLE(ren[1]), .O_PRELOAD_IMM(imm[1]), .O_BUSY(busy[1]), .O_DONE(done[1]));
  function automatic void chk(string nm, logic [63:0] g, logic [63:0] e);
    checks++;
    if (g === e) passes++;
    else $display("FAIL %s: got %0h, expected %0h", nm, g, e);
  endfunction
  function automatic step_t mk(int o, int a, int b, int s, int k, int im);
    step_t st;
    st.op = 4'(o);
    st.a = 4'(a);
    st.b = 4'(b);
    st.isel = s != 0;
    st.en = 16'd1 << k;
    st.imm = 16'(im);
    st.busy = 1'b1;
    st.done = 1'b0;
    return st;
  endfunction
  task automatic build(int i, logic [1:0] m);
    int n;
    int c;
    step_t d;
    n = i ? 16 : 8;
    c = 0;
    if (m != 2'b01) begin
      prog[i][0] = mk(13, 0, 0, 1, 0, 1);
      prog[i][1] = mk(13, 0, 0, 1, 1, 1);
      c = 2;
      for (int k = 2; k < n; k++) begin
        prog[i][c] = mk(1, k - 2, k - 1, 0, k, 0);
        c++;
      end
    end
    if (m != 2'b00)
      for (int k = 0; k < n; k++) begin
        prog[i][c] = mk(1, k, 0, 1, k, 1);
        c++;
      end
    d = '0;
    d.done = 1'b1;
    prog[i][c] = d;
    len[i] = c + 1;
    pos[i] = 0;
  endtask
  initial forever begin
    @(posedge I_CLK or negedge I_NRESET);
    for (int i = 0; i < 2; i++)
      if (!I_NRESET) begin
        len[i] = 0;
        pos[i] = 0;
      end else if (I_ENABLE) begin
        if (pos[i] < len[i]) pos[i]++;
        else if (I_START) build(i, I_MODE);
      end
  end
  initial forever begin
    @(negedge I_CLK);
    for (int i = 0; i < 2; i++) begin
      step_t e, g;
      e = (I_NRESET && pos[i] < len[i]) ? prog[i][pos[i]] : '0;
      e.en = e.en & {16{I_ENABLE}};
      g = '{op: op[i], a: asel[i], b: bsel[i], isel: isel[i], en: ren[i], imm: imm[i], busy: busy[i], done: done[i]};
      chk($sformatf("outputs%0d", i), 64'(g), 64'(e));
      if (ren[i] == 16'h8000) seen_top = 1;
      for (int r = 0; r < 16; r++)
        if (ren[i][r]) rf[i][r] = (op[i] == 4'hD) ? imm[i] : rf[i][asel[i]] + (isel[i] ? imm[i] : rf[i][bsel[i]]);
    end
  end
  task automatic wait_idle();
    int c;
    c = 0;
    while ((pos[0] < len[0] || pos[1] < len[1]) && c < 300) begin
      @(negedge I_CLK);
      c++;
    end
    chk("idle_reached", 64'(c < 300), 64'd1);
  endtask
  task automatic run(input logic [1:0] m, input logic [15:0] ev, input int act, output int lt);
    lt = 0;
    @(posedge I_CLK);
    #2 I_START = 1;
    I_MODE = m;
    @(posedge I_CLK);
    #2 I_START = 0;
    I_MODE = 2'($urandom);
    while (lt < 100) begin
      @(negedge I_CLK);
      lt++;
      if (done[0]) break;
      if (lt == 3) begin
        a3 = asel[0];
        s3 = isel[0];
      end
      if (act == 1 && ren[0] == ev) begin
        #1 I_ENABLE = 0;
        #1 chk("stall_ren_zero", 64'(ren[0]), 64'd0);
        repeat (5) @(posedge I_CLK);
        #2 I_ENABLE = 1;
        lt += 4;
        act = 0;
      end
      if (act == 2 && ren[0] == ev) begin
        #1 I_NRESET = 0;
        #1 chk("reset_mid_zero", {op[0], asel[0], bsel[0], isel[0], ren[0], imm[0], busy[0], done[0],
                                  ren[1], busy[1], done[1]}, 64'd0);
        @(posedge I_CLK);
        #2 I_NRESET = 1;
        lt = -1;
        wait_idle();
        return;
      end
      if (act == 3 && lt == 4) begin
        #1 I_START = 1;
        @(posedge I_CLK);
        #2 I_START = 0;
        act = 0;
      end
    end
    wait_idle();
  endtask
  task automatic check_fib();
    int x, y, t;
    for (int r = 0; r < 8; r++) chk($sformatf("fib8_r%0d", r), 64'(rf[0][r]), 64'(f8[r]));
    x = 1;
    y = 1;
    for (int r = 0; r < 16; r++) begin
      chk($sformatf("fib16_r%0d", r), 64'(rf[1][r]), 64'(x));
      t = x + y;
      x = y;
      y = t;
    end
  endtask
  initial begin
    f8 = '{1, 1, 2, 3, 5, 8, 13, 21};
    i8 = '{2, 2, 3, 4, 6, 9, 14, 22};
    for (int r = 0; r < 16; r++) begin
      rf[0][r] = 0;
      rf[1][r] = 0;
    end
    repeat (3) @(posedge I_CLK);
    #1 chk("reset_outputs", {op[0], asel[0], bsel[0], isel[0], ren[0], imm[0], busy[0], done[0],
                             ren[1], busy[1], done[1]}, 64'd0);
    #1 I_NRESET = 1;
    run(2'b00, 16'h0, 3, lat);
    chk("fib_done_latency", 64'(lat), 64'd9);
    check_fib();
    chk("fib16_r15_literal", 64'(rf[1][15]), 64'd987);
    chk("ren_reaches_8000", 64'(seen_top), 64'd1);
    run(2'b10, 16'h0, 0, lat);
    chk("fibinc_done_latency", 64'(lat), 64'd17);
    for (int r = 0; r < 8; r++) chk($sformatf("fibinc8_r%0d", r), 64'(rf[0][r]), 64'(i8[r]));
    for (int r = 0; r < 16; r++) begin
      rf[0][r] = 0;
      rf[1][r] = 0;
    end
    run(2'b01, 16'h0, 0, lat);
    chk("inc_done_latency", 64'(lat), 64'd9);
    chk("inc_cycle3_asel", 64'(a3), 64'd2);
    chk("inc_cycle3_immsel", 64'(s3), 64'd1);
    for (int r = 0; r < 8; r++) chk($sformatf("inc8_r%0d", r), 64'(rf[0][r]), 64'd1);
    run(2'b00, 16'h0010, 1, lat);
    chk("stall_done_latency", 64'(lat), 64'd14);
    check_fib();
    run(2'b00, 16'h0020, 2, lat);
    chk("reset_abort", 64'(lat), -64'sd1);
    run(2'b11, 16'h0, 0, lat);
    chk("after_reset_latency", 64'(lat), 64'd17);
    run(2'b00, 16'h0, 0, lat);
    chk("rerun_latency", 64'(lat), 64'd9);
    check_fib();
    for (int c = 0; c < 2000; c++) begin
      @(posedge I_CLK);
      #2 I_ENABLE = $urandom_range(0, 7) != 0;
      I_START = $urandom_range(0, 2) == 0;
      I_MODE = 2'($urandom);
      I_NRESET = $urandom_range(0, 249) != 0;
    end
    @(posedge I_CLK);
    #2 I_NRESET = 1;
    I_ENABLE = 1;
    I_START = 0;
    repeat (3) @(posedge I_CLK);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
